// File: rtl/execute_stage_if.sv
// Bundle between decode/hazard logic and the execute stage: decode-to-execute
// controls and operands in, redirect and execute-to-memory register out.
interface execute_stage_if #(
    parameter int XLEN = 32
);
    logic            Valid_E;
    logic            RegWrite_E;
    logic            MemWrite_E;
    logic            Jump_E;
    logic            Branch_E;
    logic            ALUSrc_E;
    logic [1:0]      ResultSrc_E;
    logic [3:0]      ALUControl_E;
    logic [2:0]      Funct3_E;
    logic            JalrSel_E;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] ImmExt_E;
    logic [XLEN-1:0] PC_E;
    logic [XLEN-1:0] PCPlus4_E;
    logic [4:0]      Rd_E;
    logic [1:0]      ForwardA_E;
    logic [1:0]      ForwardB_E;
    logic [XLEN-1:0] Result_W;
    logic            Stall_M;

    logic            PCSrc_E;
    logic [XLEN-1:0] PCTarget_E;
    logic            Valid_M;
    logic            RegWrite_M;
    logic            MemWrite_M;
    logic [1:0]      ResultSrc_M;
    logic [XLEN-1:0] ALUResult_M;
    logic [XLEN-1:0] WriteData_M;
    logic [XLEN-1:0] PCPlus4_M;
    logic [4:0]      Rd_M;

    modport master (
        output Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E,
               ResultSrc_E, ALUControl_E, Funct3_E, JalrSel_E,
               RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, Rd_E,
               ForwardA_E, ForwardB_E, Result_W, Stall_M,
        input  PCSrc_E, PCTarget_E, Valid_M, RegWrite_M, MemWrite_M,
               ResultSrc_M, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M
    );

    modport slave (
        input  Valid_E, RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrc_E,
               ResultSrc_E, ALUControl_E, Funct3_E, JalrSel_E,
               RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E, Rd_E,
               ForwardA_E, ForwardB_E, Result_W, Stall_M,
        output PCSrc_E, PCTarget_E, Valid_M, RegWrite_M, MemWrite_M,
               ResultSrc_M, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M
    );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// execute-to-memory pipeline register with stall and bubble handling.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    execute_stage_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [SHW-1:0]  shamt;
    logic            branch_cond;
    logic [XLEN-1:0] jalr_sum;

    logic            valid_m_reg;
    logic            regwrite_m_reg;
    logic            memwrite_m_reg;
    logic [1:0]      resultsrc_m_reg;
    logic [XLEN-1:0] aluresult_m_reg;
    logic [XLEN-1:0] writedata_m_reg;
    logic [XLEN-1:0] pcplus4_m_reg;
    logic [4:0]      rd_m_reg;

    // Forwarding from memory uses the registered ALU result of the previous op.
    always_comb begin
        fwd_a = bus.RD1_E;
        case (bus.ForwardA_E)
            2'b01:   fwd_a = bus.Result_W;
            2'b10:   fwd_a = aluresult_m_reg;
            default: fwd_a = bus.RD1_E;
        endcase
    end

    always_comb begin
        fwd_b = bus.RD2_E;
        case (bus.ForwardB_E)
            2'b01:   fwd_b = bus.Result_W;
            2'b10:   fwd_b = aluresult_m_reg;
            default: fwd_b = bus.RD2_E;
        endcase
    end

    assign src_a = fwd_a;
    assign src_b = bus.ALUSrc_E ? bus.ImmExt_E : fwd_b;
    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_result = '0;
        case (bus.ALUControl_E)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0111: alu_result = src_a << shamt;
            4'b1000: alu_result = src_a >> shamt;
            4'b1001: alu_result = $unsigned($signed(src_a) >>> shamt);
            4'b1010: alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    // Branches compare the register operands, never the immediate.
    always_comb begin
        branch_cond = 1'b0;
        case (bus.Funct3_E)
            3'b000:  branch_cond = (src_a == fwd_b);
            3'b001:  branch_cond = (src_a != fwd_b);
            3'b100:  branch_cond = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  branch_cond = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  branch_cond = (src_a <  fwd_b);
            3'b111:  branch_cond = (src_a >= fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end

    assign jalr_sum       = src_a + bus.ImmExt_E;
    assign bus.PCSrc_E    = bus.Valid_E & (bus.Jump_E | (bus.Branch_E & branch_cond));
    assign bus.PCTarget_E = bus.JalrSel_E ? {jalr_sum[XLEN-1:1], 1'b0}
                                          : (bus.PC_E + bus.ImmExt_E);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_m_reg     <= 1'b0;
            regwrite_m_reg  <= 1'b0;
            memwrite_m_reg  <= 1'b0;
            resultsrc_m_reg <= '0;
            aluresult_m_reg <= '0;
            writedata_m_reg <= '0;
            pcplus4_m_reg   <= '0;
            rd_m_reg        <= '0;
        end else if (bus.Stall_M) begin
            valid_m_reg     <= valid_m_reg;
            regwrite_m_reg  <= regwrite_m_reg;
            memwrite_m_reg  <= memwrite_m_reg;
            resultsrc_m_reg <= resultsrc_m_reg;
            aluresult_m_reg <= aluresult_m_reg;
            writedata_m_reg <= writedata_m_reg;
            pcplus4_m_reg   <= pcplus4_m_reg;
            rd_m_reg        <= rd_m_reg;
        end else if (!bus.Valid_E) begin
            valid_m_reg     <= 1'b0;
            regwrite_m_reg  <= 1'b0;
            memwrite_m_reg  <= 1'b0;
            resultsrc_m_reg <= '0;
            aluresult_m_reg <= '0;
            writedata_m_reg <= '0;
            pcplus4_m_reg   <= '0;
            rd_m_reg        <= '0;
        end else begin
            valid_m_reg     <= 1'b1;
            regwrite_m_reg  <= bus.RegWrite_E;
            memwrite_m_reg  <= bus.MemWrite_E;
            resultsrc_m_reg <= bus.ResultSrc_E;
            aluresult_m_reg <= alu_result;
            writedata_m_reg <= fwd_b;
            pcplus4_m_reg   <= bus.PCPlus4_E;
            rd_m_reg        <= bus.Rd_E;
        end
    end

    assign bus.Valid_M     = valid_m_reg;
    assign bus.RegWrite_M  = regwrite_m_reg;
    assign bus.MemWrite_M  = memwrite_m_reg;
    assign bus.ResultSrc_M = resultsrc_m_reg;
    assign bus.ALUResult_M = aluresult_m_reg;
    assign bus.WriteData_M = writedata_m_reg;
    assign bus.PCPlus4_M   = pcplus4_m_reg;
    assign bus.Rd_M        = rd_m_reg;
endmodule

// File: tb/tb_execute_stage.sv
// Directed vector bench for execute_stage: ALU, forwarding, branch/jump redirect,
// execute-to-memory register, stall vs bubble and asynchronous reset.
module tb_execute_stage;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    execute_stage_if #(.XLEN(32)) bus();

    execute_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ctl;
        logic [2:0]  f3;
        logic        valid;
        logic        rw;
        logic        mw;
        logic        jump;
        logic        br;
        logic        alusrc;
        logic        jalr;
        logic [1:0]  rsrc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] resw;
        logic [4:0]  rd;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
        logic [31:0] e_alu;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 25;
    vec_t vtab [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic stall);
        bus.ALUControl_E = v.ctl;
        bus.Funct3_E     = v.f3;
        bus.Valid_E      = v.valid;
        bus.RegWrite_E   = v.rw;
        bus.MemWrite_E   = v.mw;
        bus.Jump_E       = v.jump;
        bus.Branch_E     = v.br;
        bus.ALUSrc_E     = v.alusrc;
        bus.JalrSel_E    = v.jalr;
        bus.ResultSrc_E  = v.rsrc;
        bus.ForwardA_E   = v.fa;
        bus.ForwardB_E   = v.fb;
        bus.RD1_E        = v.rd1;
        bus.RD2_E        = v.rd2;
        bus.ImmExt_E     = v.imm;
        bus.PC_E         = v.pc;
        bus.PCPlus4_E    = v.pc + 32'd4;
        bus.Result_W     = v.resw;
        bus.Rd_E         = v.rd;
        bus.Stall_M      = stall;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, " Valid_M"},     {31'd0, bus.Valid_M},    32'd0);
        chk({tag, " RegWrite_M"},  {31'd0, bus.RegWrite_M}, 32'd0);
        chk({tag, " MemWrite_M"},  {31'd0, bus.MemWrite_M}, 32'd0);
        chk({tag, " ResultSrc_M"}, {30'd0, bus.ResultSrc_M}, 32'd0);
        chk({tag, " ALUResult_M"}, bus.ALUResult_M,         32'd0);
        chk({tag, " WriteData_M"}, bus.WriteData_M,         32'd0);
        chk({tag, " PCPlus4_M"},   bus.PCPlus4_M,           32'd0);
        chk({tag, " Rd_M"},        {27'd0, bus.Rd_M},       32'd0);
    endtask

    vec_t v;
    vec_t idle;

    initial begin
        tests = 0;
        fails = 0;
        //          ctl   f3      vl rw mw jp br as jr rs fa fb rd1            rd2            imm            pc        resw     rd  pcs tgt            alu            wd
        vtab[0]  = '{4'h0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5,         32'd7,         32'd0,         32'h100, 32'd0,   3,  0, 32'h100,       32'd12,        32'd7};
        vtab[1]  = '{4'h0, 3'b000, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 32'd99,        32'd0,         32'd1,         32'h104, 32'd0,   4,  0, 32'h105,       32'd13,        32'd0};
        vtab[2]  = '{4'h1, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'd50,        32'd123,       32'd0,         32'h108, 32'd20,  5,  0, 32'h108,       32'd30,        32'd20};
        vtab[3]  = '{4'h1, 3'b100, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'h10,        32'h200, 32'd0,   0,  1, 32'h210,       32'hFFFFFFFE,  32'd1};
        vtab[4]  = '{4'h1, 3'b110, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'h10,        32'h200, 32'd0,   0,  0, 32'h210,       32'hFFFFFFFE,  32'd1};
        vtab[5]  = '{4'h1, 3'b100, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'h10,        32'h200, 32'd0,   0,  0, 32'h210,       32'd0,         32'd0};
        vtab[6]  = '{4'h0, 3'b000, 1, 1, 0, 1, 0, 1, 1, 2, 0, 0, 32'h1003,      32'h55,        32'd4,         32'h200, 32'd0,   1,  1, 32'h1006,      32'h1007,      32'h55};
        vtab[7]  = '{4'h9, 3'b000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80000000,  32'd0,         32'd31,        32'h0,   32'd0,   6,  0, 32'd31,        32'hFFFFFFFF,  32'd0};
        vtab[8]  = '{4'h0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,   32'd0,   7,  0, 32'd0,         32'd0,         32'd1};
        vtab[9]  = '{4'hF, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5,         32'd6,         32'd0,         32'h0,   32'd0,   8,  0, 32'd0,         32'd0,         32'd6};
        vtab[10] = '{4'h2, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hF0F0,      32'hFF00,      32'd0,         32'h0,   32'd0,   9,  0, 32'd0,         32'hF000,      32'hFF00};
        vtab[11] = '{4'h3, 3'b000, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'hF0F0,      32'h0F00,      32'd0,         32'h0,   32'd0,   10, 0, 32'd0,         32'hFFF0,      32'h0F00};
        vtab[12] = '{4'h4, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFF,        32'h0F,        32'd0,         32'h0,   32'd0,   11, 0, 32'd0,         32'hF0,        32'h0F};
        vtab[13] = '{4'h5, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,   32'd0,   12, 0, 32'd0,         32'd1,         32'd1};
        vtab[14] = '{4'h6, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF,  32'd1,         32'd0,         32'h0,   32'd0,   13, 0, 32'd0,         32'd0,         32'd1};
        vtab[15] = '{4'h7, 3'b000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'd1,         32'd0,         32'd4,         32'h0,   32'd0,   14, 0, 32'd4,         32'h10,        32'd0};
        vtab[16] = '{4'h8, 3'b000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80000000,  32'd0,         32'd31,        32'h0,   32'd0,   15, 0, 32'd31,        32'd1,         32'd0};
        vtab[17] = '{4'hA, 3'b000, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0,         32'd0,         32'h12345000,  32'h0,   32'd0,   16, 0, 32'h12345000,  32'h12345000,  32'd0};
        vtab[18] = '{4'h0, 3'b000, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'd7,         32'd7,         32'd8,         32'h300, 32'd0,   0,  1, 32'h308,       32'd15,        32'd7};
        vtab[19] = '{4'h0, 3'b010, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd3,         32'd3,         32'd0,         32'h0,   32'd0,   0,  0, 32'd0,         32'd6,         32'd3};
        vtab[20] = '{4'h0, 3'b101, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd1,         32'hFFFFFFFF,  32'hFFFFFFFC,  32'h40,  32'd0,   0,  1, 32'h3C,        32'd0,         32'hFFFFFFFF};
        vtab[21] = '{4'h0, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd1,         32'hFFFFFFFF,  32'hFFFFFFFC,  32'h40,  32'd0,   0,  0, 32'h3C,        32'd0,         32'hFFFFFFFF};
        vtab[22] = '{4'h0, 3'b001, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'd1,         32'd2,         32'd0,         32'h0,   32'd0,   0,  1, 32'd0,         32'd3,         32'd2};
        vtab[23] = '{4'h0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 3, 2, 32'd10,        32'd0,         32'd0,         32'h0,   32'd777, 17, 0, 32'd0,         32'd13,        32'd3};
        vtab[24] = '{4'h0, 3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'd1,         32'd2,         32'd0,         32'h0,   32'd40,  18, 0, 32'd0,         32'd42,        32'd2};

        // Idle bubble with a pending jump: redirect must stay low.
        idle = '{4'h0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 32'h0, 32'd0, 0, 0, 32'd0, 32'd0, 32'd0};

        reset = 1'b1;
        drive(idle, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk_m_zero("reset");
        chk("reset PCSrc_E", {31'd0, bus.PCSrc_E}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vtab[i], 1'b0);
            #1;
            chk($sformatf("v%0d PCSrc_E", i),    {31'd0, bus.PCSrc_E}, {31'd0, vtab[i].e_pcsrc});
            chk($sformatf("v%0d PCTarget_E", i), bus.PCTarget_E,       vtab[i].e_tgt);
            @(posedge clk); #1;
            chk($sformatf("v%0d Valid_M", i),     {31'd0, bus.Valid_M},     {31'd0, vtab[i].valid});
            chk($sformatf("v%0d RegWrite_M", i),  {31'd0, bus.RegWrite_M},  {31'd0, vtab[i].valid & vtab[i].rw});
            chk($sformatf("v%0d MemWrite_M", i),  {31'd0, bus.MemWrite_M},  {31'd0, vtab[i].valid & vtab[i].mw});
            chk($sformatf("v%0d ResultSrc_M", i), {30'd0, bus.ResultSrc_M}, vtab[i].valid ? {30'd0, vtab[i].rsrc} : 32'd0);
            chk($sformatf("v%0d Rd_M", i),        {27'd0, bus.Rd_M},        vtab[i].valid ? {27'd0, vtab[i].rd} : 32'd0);
            chk($sformatf("v%0d PCPlus4_M", i),   bus.PCPlus4_M,            vtab[i].valid ? vtab[i].pc + 32'd4 : 32'd0);
            chk($sformatf("v%0d ALUResult_M", i), bus.ALUResult_M,          vtab[i].e_alu);
            chk($sformatf("v%0d WriteData_M", i), bus.WriteData_M,          vtab[i].e_wd);
            $display("[TB] vector %0d ctl=%h f3=%b pcsrc=%0b tgt=%08h alu_m=%08h wd_m=%08h",
                     i, vtab[i].ctl, vtab[i].f3, vtab[i].e_pcsrc, bus.PCTarget_E, bus.ALUResult_M, bus.WriteData_M);
        end

        // Store held by stall while a bubble waits upstream.
        v = vtab[0];
        v.mw = 1'b1; v.rw = 1'b0; v.alusrc = 1'b1; v.imm = 32'd8;
        v.rd1 = 32'd4; v.rd2 = 32'hAB; v.fa = 2'd0; v.fb = 2'd0; v.rd = 5'd0;
        drive(v, 1'b0);
        @(posedge clk); #1;
        chk("store MemWrite_M", {31'd0, bus.MemWrite_M}, 32'd1);
        chk("store ALUResult_M", bus.ALUResult_M, 32'd12);
        drive(idle, 1'b1);
        #1;
        chk("stall PCSrc_E", {31'd0, bus.PCSrc_E}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d MemWrite_M", c),  {31'd0, bus.MemWrite_M}, 32'd1);
            chk($sformatf("stall%0d Valid_M", c),     {31'd0, bus.Valid_M},    32'd1);
            chk($sformatf("stall%0d WriteData_M", c), bus.WriteData_M,         32'hAB);
            chk($sformatf("stall%0d ALUResult_M", c), bus.ALUResult_M,         32'd12);
            $display("[TB] stall cycle %0d memwrite_m=%0b wd_m=%08h", c, bus.MemWrite_M, bus.WriteData_M);
        end
        drive(idle, 1'b0);
        @(posedge clk); #1;
        chk("release Valid_M",     {31'd0, bus.Valid_M},    32'd0);
        chk("release MemWrite_M",  {31'd0, bus.MemWrite_M}, 32'd0);
        chk("release ALUResult_M", bus.ALUResult_M,         32'd0);
        $display("[TB] stall released valid_m=%0b memwrite_m=%0b", bus.Valid_M, bus.MemWrite_M);

        // Asynchronous reset between edges.
        v = vtab[0];
        v.rd1 = 32'd1; v.rd2 = 32'd2; v.rd = 5'd9;
        drive(v, 1'b0);
        @(posedge clk); #1;
        chk("pre-reset Valid_M",    {31'd0, bus.Valid_M},    32'd1);
        chk("pre-reset RegWrite_M", {31'd0, bus.RegWrite_M}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_m_zero("async");
        @(posedge clk); #1;
        chk_m_zero("held");
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post-reset Valid_M",     {31'd0, bus.Valid_M}, 32'd1);
        chk("post-reset ALUResult_M", bus.ALUResult_M,      32'd3);
        chk("post-reset Rd_M",        {27'd0, bus.Rd_M},    32'd9);
        $display("[TB] async reset sequence valid_m=%0b alu_m=%08h", bus.Valid_M, bus.ALUResult_M);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
